// File: rtl/ariane_pkg.sv
// Shared fetch-path types: the front-end fetch entry plus the address/data pair
// carried from the memory response side into the fetch FIFO.
package ariane_pkg;

  localparam int unsigned FETCH_WORD_BYTES = 4;
  localparam int unsigned FETCH_ADDR_W     = 64;
  localparam int unsigned FETCH_DATA_W     = 32;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] address;
    logic [FETCH_DATA_W-1:0] instruction;
  } fetch_entry_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] addr;
    logic [FETCH_DATA_W-1:0] rdata;
  } fetch_resp_t;

endpackage

// File: rtl/fetch_resp_buffer.sv
// Small registered FIFO of fetch_resp_t with a synchronous flush.
// Storage is reset so the head reads as zero straight out of reset.
module fetch_resp_buffer
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fetch_resp_t                  data_i,
  input  logic                         pop_i,
  output fetch_resp_t                  data_o,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned UW = $clog2(DEPTH + 1);

  fetch_resp_t     r_mem [DEPTH];
  logic [PW-1:0]   r_rdPtr;
  logic [PW-1:0]   r_wrPtr;
  logic [UW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (r_count == UW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign usage_o = r_count;
  assign data_o  = r_mem[r_rdPtr];

  // A push into a full buffer is accepted only when the head leaves in the same cycle.
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= data_i;
        r_wrPtr        <= ptrInc(r_wrPtr);
      end
      if (w_pop) begin
        r_rdPtr <= ptrInc(r_rdPtr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + UW'(1);
        2'b01:   r_count <= r_count - UW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_req_unit.sv
// Fetch request unit: owns the fetch PC, issues word requests under a credit limit,
// pairs returned words with their addresses and drops responses made stale by a redirect.
module fetch_req_unit
  import ariane_pkg::*;
#(
  parameter int unsigned NR_OUTSTANDING = 2,
  parameter logic [63:0] BOOT_ADDR      = 64'h0000_0000_8000_0000,
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned DATA_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_pc_i,
  input  logic [ADDR_W-1:0] npc_i,
  output logic              instr_req_o,
  output logic [ADDR_W-1:0] instr_addr_o,
  input  logic              instr_gnt_i,
  input  logic              instr_rvalid_i,
  input  logic [DATA_W-1:0] instr_rdata_i,
  output logic              fetch_valid_o,
  output logic [ADDR_W-1:0] fetch_addr_o,
  output logic [DATA_W-1:0] fetch_rdata_o,
  input  logic              fetch_ready_i
);

  localparam int unsigned CW = $clog2(NR_OUTSTANDING + 1);
  localparam int unsigned SW = CW + 2;

  logic [ADDR_W-1:0] r_pc;
  logic [CW-1:0]     r_killCnt;
  logic [CW-1:0]     w_killNext;
  logic [CW-1:0]     w_nOut;
  logic [CW-1:0]     w_nBuf;
  logic [SW-1:0]     w_inUse;
  logic [SW-1:0]     w_killSum;
  logic              w_grant;
  logic              w_rvKilled;
  logic              w_rvLive;
  logic              w_respPush;
  logic              w_respPop;
  logic              w_respFull;
  logic              w_respEmpty;
  logic              w_aqFull;
  logic              w_aqEmpty;
  fetch_resp_t       w_aqIn;
  fetch_resp_t       w_aqHead;
  fetch_resp_t       w_respIn;
  fetch_resp_t       w_respHead;
  logic              w_unusedBits;

  // The address queue occupancy is exactly the granted-but-not-returned count.
  assign w_inUse     = SW'(w_nOut) + SW'(w_nBuf) + SW'(r_killCnt);
  assign instr_req_o = !rst_i && !set_pc_i && (w_inUse < SW'(NR_OUTSTANDING));
  assign instr_addr_o = r_pc;
  assign w_grant     = instr_req_o && instr_gnt_i;
  assign w_rvKilled  = instr_rvalid_i && (r_killCnt != '0);
  assign w_rvLive    = instr_rvalid_i && (r_killCnt == '0);

  assign w_respPush = w_rvLive && !set_pc_i;
  assign w_respPop  = fetch_valid_o && fetch_ready_i;

  always_comb begin
    w_aqIn         = '0;
    w_aqIn.addr    = FETCH_ADDR_W'(r_pc);
    w_respIn       = '0;
    w_respIn.addr  = w_aqHead.addr;
    w_respIn.rdata = FETCH_DATA_W'(instr_rdata_i);
  end

  // A redirect turns every in-flight request (including one granted this cycle) into a kill credit.
  always_comb begin
    w_killSum = SW'(r_killCnt) - SW'(w_rvKilled);
    if (set_pc_i) begin
      w_killSum = w_killSum + SW'(w_nOut) + SW'(w_grant) - SW'(w_rvLive);
    end
    w_killNext = CW'(w_killSum);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc <= ADDR_W'(BOOT_ADDR);
    end else if (set_pc_i) begin
      r_pc <= {npc_i[ADDR_W-1:2], 2'b00};
    end else if (w_grant) begin
      r_pc <= r_pc + ADDR_W'(FETCH_WORD_BYTES);
    end
  end

  // The memory side shares rst_i, so nothing stale can return after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_killCnt <= '0;
    end else begin
      r_killCnt <= w_killNext;
    end
  end

  fetch_resp_buffer #(
    .DEPTH (NR_OUTSTANDING)
  ) u_addrQueue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (set_pc_i),
    .push_i  (w_grant),
    .data_i  (w_aqIn),
    .pop_i   (w_rvLive),
    .data_o  (w_aqHead),
    .usage_o (w_nOut),
    .full_o  (w_aqFull),
    .empty_o (w_aqEmpty)
  );

  fetch_resp_buffer #(
    .DEPTH (NR_OUTSTANDING)
  ) u_respBuffer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (set_pc_i),
    .push_i  (w_respPush),
    .data_i  (w_respIn),
    .pop_i   (w_respPop),
    .data_o  (w_respHead),
    .usage_o (w_nBuf),
    .full_o  (w_respFull),
    .empty_o (w_respEmpty)
  );

  assign fetch_valid_o = !w_respEmpty;
  assign fetch_addr_o  = ADDR_W'(w_respHead.addr);
  assign fetch_rdata_o = DATA_W'(w_respHead.rdata);

  assign w_unusedBits = ^{w_aqHead.rdata, npc_i[1:0]};

  a_rvalidExpected: assert property (@(posedge clk_i) disable iff (rst_i)
    instr_rvalid_i |-> (w_nOut != '0 || r_killCnt != '0));
  a_liveHasAddr: assert property (@(posedge clk_i) disable iff (rst_i)
    w_rvLive |-> !w_aqEmpty);
  a_noGrantWhenFull: assert property (@(posedge clk_i) disable iff (rst_i)
    w_grant |-> !w_aqFull);
  a_noRespOverflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (w_respPush && w_respFull) |-> w_respPop);
  a_nOutBound: assert property (@(posedge clk_i) disable iff (rst_i)
    w_nOut <= CW'(NR_OUTSTANDING));
  a_nBufBound: assert property (@(posedge clk_i) disable iff (rst_i)
    w_nBuf <= CW'(NR_OUTSTANDING));
  a_killBound: assert property (@(posedge clk_i) disable iff (rst_i)
    r_killCnt <= CW'(NR_OUTSTANDING));
  a_reqHeld: assert property (@(posedge clk_i) disable iff (rst_i)
    (instr_req_o && !instr_gnt_i) |=> (set_pc_i || (instr_req_o && $stable(instr_addr_o))));
  a_fetchHeld: assert property (@(posedge clk_i) disable iff (rst_i)
    (fetch_valid_o && !fetch_ready_i && !set_pc_i) |=>
    (fetch_valid_o && $stable(fetch_addr_o) && $stable(fetch_rdata_o)));

endmodule

// File: tb/tb_fetch_req_unit.sv
// Directed bench for fetch_req_unit: a cycle table for streaming/back-pressure,
// then hand sequences for gnt stall, redirects, PC wrap and async reset.
module tb_fetch_req_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        set_pc_i = 1'b0;
  logic [63:0] npc_i = '0;
  logic        instr_req_o;
  logic [63:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        fetch_valid_o;
  logic [63:0] fetch_addr_o;
  logic [31:0] fetch_rdata_o;
  logic        fetch_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  fetch_req_unit #(
    .NR_OUTSTANDING (2),
    .BOOT_ADDR      (64'h0000_0000_8000_0000),
    .ADDR_W         (64),
    .DATA_W         (32)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .set_pc_i       (set_pc_i),
    .npc_i          (npc_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_addr_o   (fetch_addr_o),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_ready_i  (fetch_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        expReq;
    logic [63:0] expAddr;
    logic        expValid;
    logic [63:0] expFAddr;
    logic [31:0] expFData;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic rdy,
                              input logic eReq, input logic [63:0] eAddr,
                              input logic eVal, input logic [63:0] eFAddr,
                              input logic [31:0] eFData);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rvalid = rv; v.rdata = rdata; v.ready = rdy;
    v.expReq = eReq; v.expAddr = eAddr; v.expValid = eVal;
    v.expFAddr = eFAddr; v.expFData = eFData;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_i          = v.rst;
    set_pc_i       = 1'b0;
    npc_i          = '0;
    instr_gnt_i    = v.gnt;
    instr_rvalid_i = v.rvalid;
    instr_rdata_i  = v.rdata;
    fetch_ready_i  = v.ready;
  endtask

  task automatic driveInputs(input logic setPc, input logic [63:0] npc, input logic gnt,
                             input logic rv, input logic [31:0] rdata, input logic rdy);
    set_pc_i       = setPc;
    npc_i          = npc;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rv;
    instr_rdata_i  = rdata;
    fetch_ready_i  = rdy;
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    driveInputs(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    rst_i = 1'b1;
    advance();
    rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Streaming: gnt always 1, rvalid one cycle after each grant, ready high.
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 64'h8000_0000, 0, 64'h0,         32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 1, 64'h8000_0000, 0, 64'h0,         32'h0));
    vecs.push_back(mk(0, 1, 1, 32'hC0DE_0000, 1, 1, 64'h8000_0004, 0, 64'h0,         32'h0));
    vecs.push_back(mk(0, 1, 1, 32'hC0DE_0001, 1, 0, 64'h8000_0008, 1, 64'h8000_0000, 32'hC0DE_0000));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 1, 64'h8000_0008, 1, 64'h8000_0004, 32'hC0DE_0001));
    vecs.push_back(mk(0, 1, 1, 32'hC0DE_0002, 1, 1, 64'h8000_000C, 0, 64'h0,         32'h0));
    vecs.push_back(mk(0, 1, 1, 32'hC0DE_0003, 1, 0, 64'h8000_0010, 1, 64'h8000_0008, 32'hC0DE_0002));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 1, 64'h8000_0010, 1, 64'h8000_000C, 32'hC0DE_0003));
    // Back-pressure: ready low fills the credit, then draining resumes requests.
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 64'h8000_0000, 0, 64'h0,         32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 1, 64'h8000_0000, 0, 64'h0,         32'h0));
    vecs.push_back(mk(0, 1, 1, 32'hBEEF_0000, 0, 1, 64'h8000_0004, 0, 64'h0,         32'h0));
    vecs.push_back(mk(0, 1, 1, 32'hBEEF_0001, 0, 0, 64'h8000_0008, 1, 64'h8000_0000, 32'hBEEF_0000));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 64'h8000_0008, 1, 64'h8000_0000, 32'hBEEF_0000));
    vecs.push_back(mk(0, 1, 0, 32'h0,         0, 0, 64'h8000_0008, 1, 64'h8000_0000, 32'hBEEF_0000));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 0, 64'h8000_0008, 1, 64'h8000_0000, 32'hBEEF_0000));
    vecs.push_back(mk(0, 1, 0, 32'h0,         1, 1, 64'h8000_0008, 1, 64'h8000_0004, 32'hBEEF_0001));
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 1, 64'h8000_000C, 0, 64'h0,         32'h0));

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk_i);
      checkOutput($sformatf("vec%0d req", i), instr_req_o, vecs[i].expReq);
      checkOutput($sformatf("vec%0d addr", i), instr_addr_o, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d valid", i), fetch_valid_o, vecs[i].expValid);
      if (vecs[i].expValid || vecs[i].rst) begin
        checkOutput($sformatf("vec%0d faddr", i), fetch_addr_o, vecs[i].expFAddr);
        checkOutput($sformatf("vec%0d fdata", i), fetch_rdata_o, vecs[i].expFData);
      end
      advance();
    end

    // Grant withheld: request and address hold until the grant.
    doReset();
    for (int i = 0; i < 5; i++) begin
      driveInputs(0, '0, 0, 0, '0, 1);
      @(negedge clk_i);
      checkOutput($sformatf("stall%0d req", i), instr_req_o, 1);
      checkOutput($sformatf("stall%0d addr", i), instr_addr_o, 64'h8000_0000);
      advance();
    end
    driveInputs(0, '0, 1, 0, '0, 1);
    advance();
    driveInputs(0, '0, 0, 0, '0, 1);
    @(negedge clk_i);
    checkOutput("stall pc advanced", instr_addr_o, 64'h8000_0004);
    advance();

    // Redirect with two requests in flight: both stale responses are dropped.
    doReset();
    driveInputs(0, '0, 1, 0, '0, 1);
    advance();
    driveInputs(0, '0, 1, 0, '0, 1);
    @(negedge clk_i);
    checkOutput("redir second req", instr_req_o, 1);
    advance();
    driveInputs(1, 64'h1003, 1, 0, '0, 1);
    @(negedge clk_i);
    checkOutput("redir req low", instr_req_o, 0);
    advance();
    driveInputs(0, '0, 0, 1, 32'hBAD0_0000, 1);
    @(negedge clk_i);
    checkOutput("redir new addr", instr_addr_o, 64'h1000);
    checkOutput("redir kill2 req", instr_req_o, 0);
    advance();
    driveInputs(0, '0, 0, 1, 32'hBAD0_0001, 1);
    @(negedge clk_i);
    checkOutput("redir kill1 req", instr_req_o, 1);
    checkOutput("redir stale0 valid", fetch_valid_o, 0);
    advance();
    driveInputs(0, '0, 1, 0, '0, 1);
    @(negedge clk_i);
    checkOutput("redir stale1 valid", fetch_valid_o, 0);
    advance();
    driveInputs(0, '0, 0, 1, 32'h3333_0000, 1);
    @(negedge clk_i);
    checkOutput("redir pre valid", fetch_valid_o, 0);
    advance();
    driveInputs(0, '0, 0, 0, '0, 1);
    @(negedge clk_i);
    checkOutput("redir valid", fetch_valid_o, 1);
    checkOutput("redir faddr", fetch_addr_o, 64'h1000);
    checkOutput("redir fdata", fetch_rdata_o, 32'h3333_0000);
    advance();

    // Redirect coinciding with gnt, an unkilled rvalid and a fetch handshake.
    doReset();
    driveInputs(0, '0, 1, 0, '0, 1);
    advance();
    driveInputs(0, '0, 1, 1, 32'h1111_0000, 1);
    advance();
    driveInputs(1, 64'h2000, 1, 1, 32'hDEAD_0004, 1);
    @(negedge clk_i);
    checkOutput("same req low", instr_req_o, 0);
    checkOutput("same hs valid", fetch_valid_o, 1);
    checkOutput("same hs faddr", fetch_addr_o, 64'h8000_0000);
    checkOutput("same hs fdata", fetch_rdata_o, 32'h1111_0000);
    advance();
    driveInputs(0, '0, 0, 0, '0, 1);
    @(negedge clk_i);
    checkOutput("same flushed valid", fetch_valid_o, 0);
    checkOutput("same new addr", instr_addr_o, 64'h2000);
    checkOutput("same req", instr_req_o, 1);
    advance();
    driveInputs(0, '0, 1, 0, '0, 1);
    advance();
    driveInputs(0, '0, 0, 1, 32'h2222_0000, 1);
    @(negedge clk_i);
    checkOutput("same pre valid", fetch_valid_o, 0);
    advance();
    driveInputs(0, '0, 0, 0, '0, 1);
    @(negedge clk_i);
    checkOutput("same valid", fetch_valid_o, 1);
    checkOutput("same faddr", fetch_addr_o, 64'h2000);
    checkOutput("same fdata", fetch_rdata_o, 32'h2222_0000);
    advance();

    // PC wrap at the top of the address space, then async reset with an entry pending.
    doReset();
    driveInputs(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, '0, 1);
    advance();
    driveInputs(0, '0, 1, 0, '0, 1);
    @(negedge clk_i);
    checkOutput("wrap top addr", instr_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    advance();
    driveInputs(0, '0, 0, 0, '0, 1);
    @(negedge clk_i);
    checkOutput("wrap zero addr", instr_addr_o, 64'h0);
    advance();
    driveInputs(0, '0, 0, 1, 32'h5A5A_0001, 0);
    advance();
    driveInputs(0, '0, 0, 0, '0, 0);
    @(negedge clk_i);
    checkOutput("wrap valid", fetch_valid_o, 1);
    checkOutput("wrap faddr", fetch_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    rst_i = 1'b1;
    #1;
    checkOutput("async rst valid", fetch_valid_o, 0);
    checkOutput("async rst faddr", fetch_addr_o, 64'h0);
    checkOutput("async rst fdata", fetch_rdata_o, 32'h0);
    checkOutput("async rst req", instr_req_o, 0);
    checkOutput("async rst addr", instr_addr_o, 64'h8000_0000);
    advance();
    rst_i = 1'b0;
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
